reg_file: RTL
=============

# reg_file

Eight-entry, 8-bit signed register file for the single-cycle processor. It sits around the ALU: its two read ports supply operands to the ALU, and the ALU result (for example the output of the Add unit) comes back through its write port. It also holds a small status register recording the zero and sign of the last value written.

## Interface
Parameters:
- DATA_W, 8, register width in bits (two's-complement signed).
- NUM_REGS, 8, number of registers.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W == NUM_REGS.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET_N  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- IN  input  DATA_W  write data, normally the ALU result.
- INADDRESS  input  ADDR_W  write register index.
- WRITE  input  1  write enable.
- OUT1ADDRESS  input  ADDR_W  read port 1 index (ALU operand 1).
- OUT2ADDRESS  input  ADDR_W  read port 2 index (ALU operand 2).
- OUT1  output  DATA_W  contents of register OUT1ADDRESS.
- OUT2  output  DATA_W  contents of register OUT2ADDRESS.
- ZERO  output  1  1 when the last written value was 0.
- NEG  output  1  1 when bit DATA_W-1 of the last written value was set.
- WR_VALID  output  1  pulses high for the cycle after a write commits.

## Operation
- Reset: on a rising edge with RESET_N=0:
  - all registers clear to 0;
  - ZERO=1, NEG=0, WR_VALID=0.
  - Reset overrides WRITE in the same cycle.
- Write: on a rising edge with RESET_N=1 and WRITE=1:
  - register[INADDRESS] takes IN;
  - ZERO becomes (IN==0), NEG becomes IN[DATA_W-1];
  - WR_VALID=1 for exactly the next cycle.
- When WRITE=0, registers, ZERO and NEG hold their values and WR_VALID goes to 0.
- Reads are combinational and asynchronous: OUT1/OUT2 follow address changes with no clock.
  - Both ports may read the same register.
  - Reads reflect pre-edge contents until the write edge, unless bypass is compiled in (see Configuration).
- Every index 0..NUM_REGS-1 is writable. There is no hardwired-zero register.
- Widths: IN is stored bit-exact with no extension or saturation. Overflow handling belongs to the ALU.

## Timing
- Write latency is 1 edge: a value presented in cycle N is visible on OUT1/OUT2 in cycle N+1 (without bypass).
- Read latency is 0 cycles (combinational path from address to data).
- Back-to-back writes to the same address: the last one wins at each edge.
- Reset asserted in the middle of a write sequence:
  - the next edge clears everything and discards the pending write;
  - writes resume on the first edge after RESET_N returns to 1.
- Simultaneous read and write of the same index in one cycle: OUT shows the old value, or IN with REG_BYPASS_EN.
- Outputs are undefined only before the first reset edge. The bench applies reset first.

## Configuration
- REG_BYPASS_EN defined:
  - when WRITE=1 and OUTnADDRESS==INADDRESS, OUTn shows IN combinationally in the same cycle (write-to-read forwarding);
  - ZERO/NEG are unaffected and still update at the edge.
  - The bypass is suppressed while RESET_N=0.
- REG_BYPASS_EN undefined: reads always return stored contents; no comparator logic is built.

## Structure
- Shared package reg_file_pkg holds:
  - constants DATA_W, ADDR_W, NUM_REGS;
  - typedefs data_t (signed [DATA_W-1:0]) and addr_t ([ADDR_W-1:0]).
- The ALU and decoder import the same package.
- Sub-module reg_read_port, instantiated twice: an address-indexed mux over the storage array plus the optional bypass compare/select. It is the only place REG_BYPASS_EN is tested.
- Storage, status flags and WR_VALID live in reg_file itself.

## Test plan
- Reset then read: RESET_N=0 for one edge, then read all 8 indices -> every OUT=0, ZERO=1, NEG=0, WR_VALID=0.
- Write/read: write 25 to r1 and 3 to r2 on consecutive edges, then read OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=25, OUT2=3; after the r2 write, ZERO=0, NEG=0, WR_VALID=1 for one cycle.
- Sign/zero flags:
  - write -5 (8'hFB) to r3 -> NEG=1, ZERO=0, reading r3 gives -5;
  - then write 0 to r4 -> ZERO=1, NEG=0.
- Same-cycle read/write: hold both read addresses at 5 with r5=6, write -2 to r5 -> before the edge OUT1=OUT2=6 without the macro, -2 with REG_BYPASS_EN; after the edge both give -2.
- Reset over write: r7=9, then WRITE=1, IN=100, INADDRESS=7 with RESET_N=0 -> after the edge r7=0 and WR_VALID=0.
- Write disabled: WRITE=0 with IN=77 to r0 over 3 edges -> r0 unchanged, flags unchanged, WR_VALID=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file, ALU and decoder.
package reg_file_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0]        addr_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: address mux over the storage array.
// Optional write-to-read forwarding is compiled in with REG_BYPASS_EN.
module reg_read_port #(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               addr,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rst_n,
    output logic [DATA_W-1:0]               data
);

`ifdef REG_BYPASS_EN
    // Forward the incoming write so the ALU sees it this cycle; never during reset.
    logic fwd;
    assign fwd  = rst_n && wr_en && (addr == wr_addr);
    assign data = fwd ? wr_data : regs[addr];
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data, rst_n};
    assign data          = regs[addr];
`endif

endmodule

// File: rtl/reg_file.sv
// Eight-entry signed register file with zero/sign status of the last write.
// Define REG_BYPASS_EN to forward write data to same-index reads in the same cycle.
module reg_file #(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              ZERO,
    output logic              NEG,
    output logic              WR_VALID
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic [1:0][ADDR_W-1:0]          rd_addr;
    logic [1:0][DATA_W-1:0]          rd_data;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mem      <= '0;
            ZERO     <= 1'b1;
            NEG      <= 1'b0;
            WR_VALID <= 1'b0;
        end else begin
            WR_VALID <= WRITE;
            if (WRITE) begin
                mem[INADDRESS] <= IN;
                ZERO           <= (IN == '0);
                NEG            <= IN[DATA_W-1];
            end
        end
    end

    assign rd_addr[0] = OUT1ADDRESS;
    assign rd_addr[1] = OUT2ADDRESS;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        reg_read_port #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W)
        ) u_port (
            .regs   (mem),
            .addr   (rd_addr[p]),
            .wr_en  (WRITE),
            .wr_addr(INADDRESS),
            .wr_data(IN),
            .rst_n  (RESET_N),
            .data   (rd_data[p])
        );
    end

    assign OUT1 = rd_data[0];
    assign OUT2 = rd_data[1];

endmodule
